// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster sequencer: frame FSM states,
// HDMI preamble/guard-band lengths, counter width and 640x480@60 defaults.
package video_timing_pkg;

  localparam int unsigned CNT_W        = 12;
  localparam int unsigned CNT_MAX      = 4095;
  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned GUARD_LEN    = 2;
  localparam int unsigned MIN_H_BP_PRE = 11;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam logic        DEF_HS_POL   = 1'b0;
  localparam logic        DEF_VS_POL   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } vtc_state_e;

  // Drive level of a sync line given whether the raster is inside its sync segment.
  function automatic logic sync_level(input logic in_seg, input logic pol);
    return in_seg ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vtc_axis_counter.sv
// One raster axis (horizontal or vertical): wrapping position counter plus
// decode of the ACTIVE / FP / SYNC / BP segment the position falls in.
module vtc_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic             o_wrap,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_active,
  output logic             o_fp,
  output logic             o_sync,
  output logic             o_bp
);

  localparam int unsigned      TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

  if (TOTAL > CNT_MAX || TOTAL < 2) begin : g_total_range
    $error("vtc_axis_counter: axis total %0d outside 2..%0d", TOTAL, CNT_MAX);
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next position: advance on inc, wrapping at the end of the axis.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc) begin
      if (cnt_q == LAST) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Position register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_wrap   = i_inc && (cnt_q == LAST);
  assign o_cnt    = cnt_q;
  assign o_active = (cnt_q < FP_START);
  assign o_fp     = (cnt_q >= FP_START) && (cnt_q < SYNC_START);
  assign o_sync   = (cnt_q >= SYNC_START) && (cnt_q < BP_START);
  assign o_bp     = (cnt_q >= BP_START);

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer for the HDMI path. Compile with VTC_HDMI_PREAMBLE_EN defined
// to add the HDMI video preamble on o_ctrl1 and the o_video_gb guard-band flag.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = DEF_HS_POL,
  parameter logic        VS_POL   = DEF_VS_POL
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic             o_pix_req,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_de,
  output logic [1:0]       o_ctrl0,
  output logic [1:0]       o_ctrl1,
  output logic [1:0]       o_ctrl2,
  output logic             o_video_gb,
  output logic             o_frame_start,
  output logic             o_busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_range
    $error("video_timing_ctrl: H_TOTAL/V_TOTAL exceed %0d", CNT_MAX);
  end

  vtc_state_e       state_q;
  vtc_state_e       state_d;
  logic             running_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  logic             h_active_s, h_fp_s, h_sync_s, h_bp_s;
  logic             v_active_s, v_fp_s, v_sync_s, v_bp_s;
  logic             pre_s;
  logic             gb_s;
  logic             unused_seg_s;

  // Stage 1 holds the request-side view (position whose pixel is fetched next);
  // stage 2 is the same position one cycle later, aligned with o_de.
  logic             pix_req_q, pix_req_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             p1_hs_q, p1_hs_d, p1_vs_q, p1_vs_d;
  logic             p1_fs_q, p1_fs_d, p1_busy_q, p1_busy_d;
  logic             p1_pre_q, p1_pre_d, p1_gb_q, p1_gb_d;
  logic             de_q, de_d, gb_q, gb_d, fs_q, fs_d, busy_q, busy_d;
  logic [1:0]       ctrl0_q, ctrl0_d, ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;

  assign running_s    = (state_q != ST_IDLE);
  assign unused_seg_s = ^{h_fp_s, h_bp_s, v_fp_s, v_bp_s};

  vtc_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (running_s),
    .o_wrap   (h_wrap_s),
    .o_cnt    (h_cnt_s),
    .o_active (h_active_s),
    .o_fp     (h_fp_s),
    .o_sync   (h_sync_s),
    .o_bp     (h_bp_s)
  );

  vtc_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (h_wrap_s),
    .o_wrap   (v_wrap_s),
    .o_cnt    (v_cnt_s),
    .o_active (v_active_s),
    .o_fp     (v_fp_s),
    .o_sync   (v_sync_s),
    .o_bp     (v_bp_s)
  );

  // Frame FSM; v_wrap_s marks the last clock of a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!i_enable) state_d = v_wrap_s ? ST_IDLE : ST_DRAIN;
        else           state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (i_enable)      state_d = ST_RUN;
        else if (v_wrap_s) state_d = ST_IDLE;
        else               state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef VTC_HDMI_PREAMBLE_EN
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] PRE_START = CNT_W'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [CNT_W-1:0] GB_START  = CNT_W'(H_TOTAL - GUARD_LEN);

  if (H_BP < MIN_H_BP_PRE) begin : g_bp_check
    $error("video_timing_ctrl: H_BP=%0d too short for the HDMI preamble", H_BP);
  end

  logic [CNT_W-1:0] v_next_s;
  logic             line_pre_s;

  // Preamble/guard band precede a line only if that line is active and the
  // raster actually continues into it (not the tail of a draining frame).
  always_comb begin
    v_next_s   = (v_cnt_s == V_LAST) ? {CNT_W{1'b0}} : (v_cnt_s + CNT_W'(1));
    line_pre_s = running_s && (v_next_s < V_ACT_END) &&
                 !((v_cnt_s == V_LAST) && (state_q == ST_DRAIN) && !i_enable);
    pre_s      = line_pre_s && (h_cnt_s >= PRE_START) && (h_cnt_s < GB_START);
    gb_s       = line_pre_s && (h_cnt_s >= GB_START);
  end
`else
  assign pre_s = 1'b0;
  assign gb_s  = 1'b0;
`endif

  // Stage 1: request-side decode of the current raster position.
  always_comb begin
    pix_req_d = running_s && h_active_s && v_active_s;
    x_d       = h_cnt_s;
    y_d       = v_cnt_s;
    p1_hs_d   = running_s && h_sync_s;
    p1_vs_d   = running_s && v_sync_s;
    p1_fs_d   = running_s && (h_cnt_s == {CNT_W{1'b0}}) && (v_cnt_s == {CNT_W{1'b0}});
    p1_busy_d = running_s;
    p1_pre_d  = pre_s;
    p1_gb_d   = gb_s;
  end

  // Stage 2: encoder-facing outputs, one cycle behind the request.
  always_comb begin
    de_d    = pix_req_q;
    ctrl0_d = {sync_level(p1_vs_q, VS_POL), sync_level(p1_hs_q, HS_POL)};
    ctrl1_d = p1_pre_q ? 2'b01 : 2'b00;
    ctrl2_d = 2'b00;
    gb_d    = p1_gb_q;
    fs_d    = p1_fs_q;
    busy_d  = p1_busy_q;
  end

  // State and pipeline registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      pix_req_q <= 1'b0;
      x_q       <= {CNT_W{1'b0}};
      y_q       <= {CNT_W{1'b0}};
      p1_hs_q   <= 1'b0;
      p1_vs_q   <= 1'b0;
      p1_fs_q   <= 1'b0;
      p1_busy_q <= 1'b0;
      p1_pre_q  <= 1'b0;
      p1_gb_q   <= 1'b0;
      de_q      <= 1'b0;
      ctrl0_q   <= {~VS_POL, ~HS_POL};
      ctrl1_q   <= 2'b00;
      ctrl2_q   <= 2'b00;
      gb_q      <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_req_q <= pix_req_d;
      x_q       <= x_d;
      y_q       <= y_d;
      p1_hs_q   <= p1_hs_d;
      p1_vs_q   <= p1_vs_d;
      p1_fs_q   <= p1_fs_d;
      p1_busy_q <= p1_busy_d;
      p1_pre_q  <= p1_pre_d;
      p1_gb_q   <= p1_gb_d;
      de_q      <= de_d;
      ctrl0_q   <= ctrl0_d;
      ctrl1_q   <= ctrl1_d;
      ctrl2_q   <= ctrl2_d;
      gb_q      <= gb_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
    end
  end

  assign o_pix_req     = pix_req_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_de          = de_q;
  assign o_ctrl0       = ctrl0_q;
  assign o_ctrl1       = ctrl1_q;
  assign o_ctrl2       = ctrl2_q;
  assign o_video_gb    = gb_q;
  assign o_frame_start = fs_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl on small raster parameters;
// honours VTC_HDMI_PREAMBLE_EN to check either the HDMI or the DVI build.
module tb_video_timing_ctrl;

  localparam int HA = 8;
`ifdef VTC_HDMI_PREAMBLE_EN
  localparam int HF = 9;
  localparam int HB = 11;
`else
  localparam int HF = 2;
  localparam int HB = 3;
`endif
  localparam int HS = 3;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic HP = 1'b0;
  localparam logic VP = 1'b0;
  localparam int K_INF = 1 << 30;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        pix_req;
  logic [11:0] x;
  logic [11:0] y;
  logic        de;
  logic [1:0]  c0;
  logic [1:0]  c1;
  logic [1:0]  c2;
  logic        gb;
  logic        fs;
  logic        busy;

  int n_tests;
  int n_fail;

  typedef struct {
    int de; int pix; int c0; int c1; int gb; int fs; int busy; int x; int y;
  } exp_t;

  typedef struct {
    int h; int v; int de; int c0; int fs;
  } vec_t;

  vec_t tbl [13];
  int   cap_de [0:VT-1][0:HT-1];
  int   cap_c0 [0:VT-1][0:HT-1];
  int   cap_fs [0:VT-1][0:HT-1];
  int   sb_q [$];

  video_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (HP), .VS_POL (VP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .o_pix_req     (pix_req),
    .o_x           (x),
    .o_y           (y),
    .o_de          (de),
    .o_ctrl0       (c0),
    .o_ctrl1       (c1),
    .o_ctrl2       (c2),
    .o_video_gb    (gb),
    .o_frame_start (fs),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int b2i(input bit b);
    return b ? 1 : 0;
  endfunction

  // Expected outputs at output cycle k (k=0 is the first frame_start); k_end is
  // the first cycle after the last frame, K_INF while enable stays on.
  function automatic exp_t model(input int k, input int k_end);
    exp_t e;
    int h, v, hn, vn, hs_l, vs_l;
    e.de = 0; e.pix = 0; e.c0 = 3; e.c1 = 0; e.gb = 0; e.fs = 0; e.busy = 0;
    e.x = 0; e.y = 0;
    if (k >= 0 && k < k_end) begin
      h      = k % HT;
      v      = (k / HT) % VT;
      e.busy = 1;
      e.de   = b2i(h < HA && v < VA);
      e.fs   = b2i(h == 0 && v == 0);
      hs_l   = (h >= HA + HF && h < HA + HF + HS) ? b2i(HP) : b2i(!HP);
      vs_l   = (v >= VA + VF && v < VA + VF + VS) ? b2i(VP) : b2i(!VP);
      e.c0   = 2 * vs_l + hs_l;
`ifdef VTC_HDMI_PREAMBLE_EN
      if (((v + 1) % VT) < VA && (k - h + HT) < k_end) begin
        if (h >= HT - 10 && h < HT - 2) e.c1 = 1;
        if (h >= HT - 2) e.gb = 1;
      end
`endif
    end
    if (k + 1 >= 0 && k + 1 < k_end) begin
      hn    = (k + 1) % HT;
      vn    = ((k + 1) / HT) % VT;
      e.pix = b2i(hn < HA && vn < VA);
      e.x   = hn;
      e.y   = vn;
    end
    return e;
  endfunction

  task automatic check_cycle(input int k, input int k_end);
    exp_t e;
    e = model(k, k_end);
    chk($sformatf("de@%0d", k), int'(de), e.de);
    chk($sformatf("pix_req@%0d", k), int'(pix_req), e.pix);
    chk($sformatf("ctrl0@%0d", k), int'(c0), e.c0);
    chk($sformatf("ctrl1@%0d", k), int'(c1), e.c1);
    chk($sformatf("ctrl2@%0d", k), int'(c2), 0);
    chk($sformatf("video_gb@%0d", k), int'(gb), e.gb);
    chk($sformatf("frame_start@%0d", k), int'(fs), e.fs);
    chk($sformatf("busy@%0d", k), int'(busy), e.busy);
    if (e.pix == 1) begin
      chk($sformatf("x@%0d", k), int'(x), e.x);
      chk($sformatf("y@%0d", k), int'(y), e.y);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_pix_req"}, int'(pix_req), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_ctrl0"}, int'(c0), 3);
    chk({tag, "_ctrl1"}, int'(c1), 0);
    chk({tag, "_ctrl2"}, int'(c2), 0);
    chk({tag, "_gb"}, int'(gb), 0);
    chk({tag, "_fs"}, int'(fs), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int k_end;
    int prev_pix;
    int last_fs;
    int exp_xy;
    int waited;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    en      = 1'b0;

    // {position, expected de, ctrl0, frame_start} probe vectors
    tbl[0]  = '{0, 0, 1, 3, 1};
    tbl[1]  = '{3, 1, 1, 3, 0};
    tbl[2]  = '{HA - 1, VA - 1, 1, 3, 0};
    tbl[3]  = '{HA, 0, 0, 3, 0};
    tbl[4]  = '{HA + HF, 0, 0, 2, 0};
    tbl[5]  = '{HA + HF + HS - 1, 2, 0, 2, 0};
    tbl[6]  = '{HA + HF + HS, 1, 0, 3, 0};
    tbl[7]  = '{HT - 1, 3, 0, 3, 0};
    tbl[8]  = '{0, VA, 0, 3, 0};
    tbl[9]  = '{0, VA + VF, 0, 1, 0};
    tbl[10] = '{HA + HF, VA + VF, 0, 0, 0};
    tbl[11] = '{5, VA + VF + VS, 0, 3, 0};
    tbl[12] = '{HT - 1, VT - 1, 0, 3, 0};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      tick();
      check_cycle(-5, 0);
    end

    // Continuous run, then drop enable at output position h=5, v=1 of frame 2.
    en = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int v = 0; v < VA; v++)
        for (int h = 0; h < HA; h++)
          sb_q.push_back(v * 4096 + h);
    k_end    = K_INF;
    prev_pix = 0;
    last_fs  = -1;
    for (int k = -2; k <= 3 * HT * VT + 20; k++) begin
      tick();
      check_cycle(k, k_end);
      if (pix_req === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          exp_xy = sb_q.pop_front();
          chk($sformatf("sb_xy@%0d", k), int'(y) * 4096 + int'(x), exp_xy);
        end
      end
      if (de === 1'b1) chk($sformatf("req_before_de@%0d", k), prev_pix, 1);
      prev_pix = int'(pix_req);
      if (fs === 1'b1) begin
        if (last_fs >= 0) chk("fs_period", k - last_fs, HT * VT);
        last_fs = k;
      end
      if (k >= 0 && k < HT * VT) begin
        cap_de[k / HT][k % HT] = int'(de);
        cap_c0[k / HT][k % HT] = int'(c0);
        cap_fs[k / HT][k % HT] = int'(fs);
      end
      if (k == 2 * HT * VT + HT + 5) begin
        en    = 1'b0;
        k_end = 3 * HT * VT;
      end
    end
    chk("sb_leftover", sb_q.size(), 0);

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d_de", i), cap_de[tbl[i].v][tbl[i].h], tbl[i].de);
      chk($sformatf("vec%0d_ctrl0", i), cap_c0[tbl[i].v][tbl[i].h], tbl[i].c0);
      chk($sformatf("vec%0d_fs", i), cap_fs[tbl[i].v][tbl[i].h], tbl[i].fs);
    end

    // Drop enable at h=5, v=1 and bring it back at v=6: no gap into frame 1.
    en = 1'b1;
    for (int k = -2; k <= 2 * HT * VT + 3; k++) begin
      tick();
      check_cycle(k, K_INF);
      if (k == HT + 5) en = 1'b0;
      if (k == 6 * HT) en = 1'b1;
    end

    // Asynchronous reset at h=3, v=0, mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = -2; k <= HT * VT + 12; k++) begin
      tick();
      check_cycle(k, K_INF);
      if (k == 0) chk("restart_fs", int'(fs), 1);
    end

    en     = 1'b0;
    waited = 0;
    while (busy !== 1'b0 && waited < 4 * HT * VT) begin
      tick();
      waited++;
    end
    chk("final_drain_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
